cache_miss_handler: RTL
=======================

CACHE_MISS_HANDLER -- requirements
Module: cache_miss_handler

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, max cycles waiting for mem_ack.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_b, input, 1, reset; synchronous, active-high: asserted = 1, sampled on posedge clk.
REQ-005 SHALL have CPU-side ports, all inputs held stable until cpu_ready:
- cpu_req, in, 1
- cpu_we, in, 1
- cpu_is_byte, in, 1
- cpu_addr, in, 32
- cpu_wdata, in, 32
- cpu_rdata, out, 32
- cpu_ready, out, 1: one-cycle completion pulse
REQ-006 SHALL have cache-side ports:
- cache_hit, cache_dirty, in, 1
- cache_miss_addr, in, 32: victim line address
- cache_rdata, in, 32
- cache_addr, out, 32
- cache_wdata, out, 32
- cache_we, out, 1
- cache_is_byte, out, 1
REQ-007 SHALL have memory-side ports:
- mem_req, mem_we, out, 1
- mem_addr, mem_wdata, out, 32
- mem_rdata, in, 32
- mem_ack, in, 1: one-cycle pulse
REQ-008 SHALL have status ports:
- mem_err, out, 1: sticky
- miss_count, out, 32
- wb_count, out, 32

Function
REQ-009 SHALL implement states IDLE, LOOKUP, WRITEBACK, FILL, ERROR.
REQ-010 IDLE: cpu_req=1 -> LOOKUP next cycle; otherwise remain.
REQ-011 cache_addr SHALL equal cpu_addr in LOOKUP and FILL.
- cache_addr SHALL equal cpu_addr in WRITEBACK.
- cache_addr SHALL be 0 in IDLE and ERROR.
REQ-012 LOOKUP, read hit:
- cpu_rdata = cache_rdata and cpu_ready=1 in the same cycle.
- -> IDLE.
REQ-013 LOOKUP, write hit:
- cache_we=1, cache_wdata=cpu_wdata, cache_is_byte=cpu_is_byte, cpu_ready=1 in the same cycle.
- -> IDLE.
REQ-014 LOOKUP, miss: miss_count increments by 1; cache_dirty=1 -> WRITEBACK; else -> FILL.
REQ-015 WRITEBACK: mem_req=1, mem_we=1, mem_addr=cache_miss_addr, mem_wdata=cache_rdata, cache_is_byte=0; held until mem_ack.
- On mem_ack: wb_count increments by 1; -> FILL.
REQ-016 FILL: mem_req=1, mem_we=0, mem_addr={cpu_addr[31:2],2'b00}; held until mem_ack.
- On mem_ack: cache_we=1, cache_is_byte=0, cache_wdata=mem_rdata in that cycle; -> LOOKUP.
- The re-lookup SHALL hit, so miss completion = hit path + 1 cycle.
REQ-017 Hit latency SHALL be 2 cycles from cpu_req sample to cpu_ready.
- Clean-miss latency = 2 + fill wait + 2.
REQ-018 A byte write miss SHALL fill the full word first, then merge the byte in the re-LOOKUP write hit; the cache sets dirty on that write.
REQ-019 A timeout counter SHALL clear on entry to WRITEBACK/FILL and increment each waiting cycle.
- Reaching MEM_TIMEOUT without mem_ack -> ERROR: mem_req=0, mem_err=1.
- ERROR is exited only by reset; cpu_ready is never asserted in ERROR.
REQ-020 mem_ack outside WRITEBACK/FILL SHALL be ignored.
- mem_ack on the cycle the timeout is reached SHALL take priority (no error).
REQ-021 Counters SHALL wrap modulo 2^32 without flagging.
REQ-022 cpu_rdata SHALL be 0 whenever cpu_ready=0.
REQ-023 cache_we SHALL never assert in IDLE, WRITEBACK or ERROR.

Reset
REQ-024 On rst_b=1 at posedge clk:
- state=IDLE; all outputs 0, including mem_err, miss_count, wb_count and the timeout counter.
REQ-025 Reset mid-WRITEBACK/FILL SHALL drop mem_req the following cycle; no cache write SHALL occur.

Structure
REQ-026 A shared package SHALL hold:
- the state enum;
- constants TAG_W=19, INDEX_W=11, OFFSET_W=2, line-address mask;
- word<->byte-array packing function (big-endian: byte 0 at ea+3).
REQ-027 SHALL contain one sub-module, mh_timeout_counter (clear, enable, terminal-count flag).

Verification
REQ-028 Read hit at 0x0000_0010 with cache_rdata=0xDEADBEEF -> cpu_ready 2 cycles after cpu_req, cpu_rdata=0xDEADBEEF, no mem_req.
REQ-029 Clean read miss at 0x0002_0010, mem_ack after 5 cycles, mem_rdata=0x12345678:
- expected: one FILL at mem_addr 0x0002_0010, cache_we pulse, then cpu_rdata=0x12345678; miss_count=1.
REQ-030 Dirty miss with cache_miss_addr=0x0000_0010:
- expected: WRITEBACK at mem_addr 0x0000_0010 with mem_we=1, then FILL; wb_count=1.
REQ-031 Byte write miss at 0x0002_0013 with cpu_wdata=0xAB:
- expected: word fill, then cache_we with cache_is_byte=1, cache_wdata=0xAB.
REQ-032 mem_ack withheld with MEM_TIMEOUT=4 -> ERROR after 4 waiting cycles, mem_err=1, mem_req=0; cleared only by rst_b=1.
REQ-033 rst_b=1 during FILL:
- expected: next cycle mem_req=0, state IDLE, counters 0, no cache_we.

Source files
------------

// File: rtl/cache_miss_handler_pkg.sv
// Shared definitions for the cache miss handler: FSM encoding, address-split
// widths and big-endian word/byte packing helpers.
package cache_miss_handler_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_ERROR     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_LOOKUP    = S_LOOKUP,
        ST_WRITEBACK = S_WRITEBACK,
        ST_FILL      = S_FILL,
        ST_ERROR     = S_ERROR
    } mh_state_e;

    localparam int TAG_W    = 19;
    localparam int INDEX_W  = 11;
    localparam int OFFSET_W = 2;

    localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFFC;

    // Index is the byte offset from the word address: byte at ea+3 is the LSB.
    typedef logic [3:0][7:0] mh_bytes_t;

    function automatic mh_bytes_t word_to_bytes(input logic [31:0] word);
        mh_bytes_t b;
        for (int i = 0; i < 4; i++) begin
            b[i] = word[8*(3-i) +: 8];
        end
        return b;
    endfunction

    function automatic logic [31:0] bytes_to_word(input mh_bytes_t b);
        logic [31:0] word;
        for (int i = 0; i < 4; i++) begin
            word[8*(3-i) +: 8] = b[i];
        end
        return word;
    endfunction

endpackage

// File: rtl/cache_miss_handler_timeout_counter.sv
// Memory-wait watchdog: counts waiting cycles and flags the last permitted one.
module mh_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    // Saturates at the terminal value so the flag stays stable until cleared.
    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_terminal = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/cache_miss_handler.sv
// Blocking cache miss handler: hit service, dirty-victim writeback, line fill
// with re-lookup, and a sticky error state when memory stops answering.
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_b,

    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic            cpu_is_byte,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_ready,

    input  logic            cache_hit,
    input  logic            cache_dirty,
    input  logic [XLEN-1:0] cache_miss_addr,
    input  logic [XLEN-1:0] cache_rdata,
    output logic [XLEN-1:0] cache_addr,
    output logic [XLEN-1:0] cache_wdata,
    output logic            cache_we,
    output logic            cache_is_byte,

    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,

    output logic            mem_err,
    output logic [XLEN-1:0] miss_count,
    output logic [XLEN-1:0] wb_count
);

    mh_state_e       r_state;
    mh_state_e       w_next;
    logic [XLEN-1:0] r_miss_count;
    logic [XLEN-1:0] r_wb_count;
    logic            w_waiting;
    logic            w_clear;
    logic            w_terminal;

    assign w_waiting = (r_state == ST_WRITEBACK) || (r_state == ST_FILL);
    assign w_clear   = ((w_next == ST_WRITEBACK) || (w_next == ST_FILL)) && (w_next != r_state);

    mh_timeout_counter #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .i_rst     (rst_b),
        .i_clear   (w_clear),
        .i_enable  (w_waiting && !mem_ack),
        .o_terminal(w_terminal)
    );

    // An ack arriving on the terminal cycle wins over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (cpu_req) w_next = ST_LOOKUP;
            ST_LOOKUP: begin
                if (cache_hit)        w_next = ST_IDLE;
                else if (cache_dirty) w_next = ST_WRITEBACK;
                else                  w_next = ST_FILL;
            end
            ST_WRITEBACK: begin
                if (mem_ack)         w_next = ST_FILL;
                else if (w_terminal) w_next = ST_ERROR;
            end
            ST_FILL: begin
                if (mem_ack)         w_next = ST_LOOKUP;
                else if (w_terminal) w_next = ST_ERROR;
            end
            ST_ERROR:     w_next = ST_ERROR;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state      <= ST_IDLE;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_LOOKUP) && !cache_hit) begin
                r_miss_count <= r_miss_count + XLEN'(1);
            end
            if ((r_state == ST_WRITEBACK) && mem_ack) begin
                r_wb_count <= r_wb_count + XLEN'(1);
            end
        end
    end

    // Completion and cache writes are suppressed while reset is being applied.
    always_comb begin
        cpu_rdata     = '0;
        cpu_ready     = 1'b0;
        cache_addr    = '0;
        cache_wdata   = '0;
        cache_we      = 1'b0;
        cache_is_byte = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (r_state)
            ST_LOOKUP: begin
                cache_addr = cpu_addr;
                if (cache_hit && !rst_b) begin
                    cpu_ready = 1'b1;
                    if (cpu_we) begin
                        cache_we      = 1'b1;
                        cache_wdata   = cpu_wdata;
                        cache_is_byte = cpu_is_byte;
                    end else begin
                        cpu_rdata = cache_rdata;
                    end
                end
            end
            ST_WRITEBACK: begin
                cache_addr = cpu_addr;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = cache_miss_addr;
                mem_wdata  = cache_rdata;
            end
            ST_FILL: begin
                cache_addr = cpu_addr;
                mem_req    = 1'b1;
                mem_addr   = {cpu_addr[XLEN-1:OFFSET_W], {OFFSET_W{1'b0}}};
                if (mem_ack && !rst_b) begin
                    cache_we    = 1'b1;
                    cache_wdata = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_err    = (r_state == ST_ERROR);
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;

endmodule
